// File: rtl/micro_bitos_mc.sv
// micro_bitos_mc: parametrised multicycle MicroBitos core with req/ack instruction and data buses.
// BOOT/FETCH/EXEC/MEM/HALT state machine, {N,C,Z} flags register and a hard-wired zero R0.
module micro_bitos_mc #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int ADDR_W     = 8,
  localparam int INSTR_W   = 4 + 3*REG_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] i_imem_data,
  input  logic               i_imem_ack,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [DATA_W-1:0]  i_dmem_rdata,
  input  logic               i_dmem_ack,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [ADDR_W-1:0]  o_dmem_addr,
  output logic [DATA_W-1:0]  o_dmem_wdata,
  output logic [2:0]         o_flags,
  output logic               o_halted
);
  localparam int NREG = 2**REG_ADDR_W;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_EXEC, S_MEM, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
    OP_LDI, OP_MOV, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC, OP_HALT
  } op_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc, rs1_addr;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [2:0]          flags_q;
  logic [ADDR_W-1:0]   dmem_addr_q;
  logic                dmem_we_q;
  logic [DATA_W-1:0]   dmem_wdata_q;

  op_t                 op;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0]   imm, opa, opb, alu_res, wr_data;
  logic [DATA_W:0]     wide;
  logic                alu_c, wr_en, flags_en, mem_issue;

  // Decode and operand fetch; R0 is forced to zero on read.
  always_comb begin
    op       = op_t'(ir_q[INSTR_W-1 -: 4]);
    rd       = ir_q[3*REG_ADDR_W-1 -: REG_ADDR_W];
    rs1      = ir_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
    rs2      = ir_q[REG_ADDR_W-1:0];
    imm      = DATA_W'(ir_q[2*REG_ADDR_W-1:0]);
    opa      = (rs1 == '0) ? '0 : regs_q[rs1];
    opb      = (rs2 == '0) ? '0 : regs_q[rs2];
    rs1_addr = ADDR_W'(opa);
    pc_inc   = pc_q + ADDR_W'(1);
  end

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = flags_q[1];
    case (op)
      OP_ADD: begin
        wide    = {1'b0, opa} + {1'b0, opb};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      // Borrow appears as the extra top bit of the widened difference.
      OP_SUB: begin
        wide    = {1'b0, opa} - {1'b0, opb};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_AND: begin alu_res = opa & opb; alu_c = 1'b0; end
      OP_OR:  begin alu_res = opa | opb; alu_c = 1'b0; end
      OP_XOR: begin alu_res = opa ^ opb; alu_c = 1'b0; end
      OP_SHL: begin alu_res = {opa[DATA_W-2:0], 1'b0}; alu_c = opa[DATA_W-1]; end
      OP_SHR: begin alu_res = {1'b0, opa[DATA_W-1:1]}; alu_c = opa[0]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wr_en     = 1'b0;
    wr_data   = alu_res;
    flags_en  = 1'b0;
    mem_issue = 1'b0;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (i_imem_ack) state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            wr_en    = 1'b1;
            flags_en = 1'b1;
          end
          OP_LDI: begin wr_en = 1'b1; wr_data = imm; end
          OP_MOV: begin wr_en = 1'b1; wr_data = opa; end
          OP_LD, OP_ST: begin
            pc_d      = pc_q;
            mem_issue = 1'b1;
            state_d   = S_MEM;
          end
          OP_JMP: pc_d = rs1_addr;
          OP_JZ:  if (flags_q[0]) pc_d = rs1_addr;
          OP_JC:  if (flags_q[1]) pc_d = rs1_addr;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_MEM: if (i_dmem_ack) begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        wr_en   = ~dmem_we_q;
        wr_data = i_dmem_rdata;
      end
      S_HALT:  ;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_BOOT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      ir_q         <= '0;
      flags_q      <= '0;
      regs_q       <= '{default: '0};
      dmem_addr_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_wdata_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (state_q == S_FETCH && i_imem_ack) ir_q <= i_imem_data;
      if (wr_en && rd != '0) regs_q[rd] <= wr_data;
      if (flags_en) flags_q <= {alu_res[DATA_W-1], alu_c, alu_res == '0};
      // Data-bus address/data are latched once in EXEC so they stay stable across wait states.
      if (mem_issue) begin
        dmem_addr_q  <= rs1_addr;
        dmem_we_q    <= (op == OP_ST);
        dmem_wdata_q <= opb;
      end
    end
  end

  assign o_imem_req   = (state_q == S_FETCH);
  assign o_imem_addr  = pc_q;
  assign o_dmem_req   = (state_q == S_MEM);
  assign o_dmem_we    = dmem_we_q;
  assign o_dmem_addr  = dmem_addr_q;
  assign o_dmem_wdata = dmem_wdata_q;
  assign o_flags      = flags_q;
  assign o_halted     = (state_q == S_HALT);
endmodule

// File: tb/tb_micro_bitos_mc.sv
// Bench for micro_bitos_mc: directed scenarios plus random programs on an 8/3 and a 16/4 core,
// checked against an instruction-level reference model of the architectural state.
module tb_micro_bitos_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset, sel;
  logic [15:0] imem_data, dmem_rdata;
  logic        imem_ack, dmem_ack;

  logic       ireq0, dreq0, we0, halt0;
  logic [7:0] iaddr0, daddr0, wdata0;
  logic [2:0] flags0;
  logic        ireq1, dreq1, we1, halt1;
  logic [7:0]  iaddr1, daddr1;
  logic [15:0] wdata1;
  logic [2:0]  flags1;

  micro_bitos_mc #(.DATA_W(8), .REG_ADDR_W(3), .ADDR_W(8)) dut0 (
    .clk(clk), .reset(reset),
    .i_imem_data(imem_data[12:0]), .i_imem_ack(imem_ack), .o_imem_req(ireq0), .o_imem_addr(iaddr0),
    .i_dmem_rdata(dmem_rdata[7:0]), .i_dmem_ack(dmem_ack), .o_dmem_req(dreq0), .o_dmem_we(we0),
    .o_dmem_addr(daddr0), .o_dmem_wdata(wdata0), .o_flags(flags0), .o_halted(halt0));

  micro_bitos_mc #(.DATA_W(16), .REG_ADDR_W(4), .ADDR_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .i_imem_data(imem_data), .i_imem_ack(imem_ack), .o_imem_req(ireq1), .o_imem_addr(iaddr1),
    .i_dmem_rdata(dmem_rdata), .i_dmem_ack(dmem_ack), .o_dmem_req(dreq1), .o_dmem_we(we1),
    .o_dmem_addr(daddr1), .o_dmem_wdata(wdata1), .o_flags(flags1), .o_halted(halt1));

  logic        g_ireq, g_dreq, g_we, g_halt;
  logic [7:0]  g_iaddr, g_daddr;
  logic [15:0] g_wdata;
  logic [2:0]  g_flags;
  assign g_ireq  = sel ? ireq1  : ireq0;
  assign g_dreq  = sel ? dreq1  : dreq0;
  assign g_we    = sel ? we1    : we0;
  assign g_halt  = sel ? halt1  : halt0;
  assign g_iaddr = sel ? iaddr1 : iaddr0;
  assign g_daddr = sel ? daddr1 : daddr0;
  assign g_wdata = sel ? wdata1 : {8'h00, wdata0};
  assign g_flags = sel ? flags1 : flags0;

  // Reference model: architectural state only.
  int unsigned dw, ra, dmask, rmask;
  int unsigned mreg [16];
  logic [2:0]  mflags;
  int unsigned mpc;
  int unsigned imem [256];
  int unsigned dmem [256];
  int checks = 0;
  int errors = 0;
  int c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input bit s);
    sel   = s;
    dw    = s ? 16 : 8;
    ra    = s ? 4 : 3;
    dmask = (32'd1 << dw) - 1;
    rmask = (32'd1 << ra) - 1;
  endtask

  function automatic int unsigned enc(input int unsigned op, input int unsigned rd,
                                      input int unsigned rs1, input int unsigned rs2);
    return (op << (3*ra)) | (rd << (2*ra)) | (rs1 << ra) | rs2;
  endfunction

  function automatic int unsigned ldi(input int unsigned rd, input int unsigned imm);
    return enc(8, rd, (imm >> ra) & rmask, imm & rmask);
  endfunction

  task automatic fill_imem(input int unsigned op);
    for (int i = 0; i < 256; i++) imem[8'(i)] = enc(op, 0, 0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[4'(i)] = 0;
    mflags = 3'b000;
    mpc    = 0;
  endtask

  task automatic wr(input int unsigned rd, input int unsigned v);
    if (rd != 0) mreg[4'(rd)] = v & dmask;
  endtask

  // kind: 0 register/jump op, 1 LD, 2 HALT, 3 ST
  task automatic model_step(input int unsigned w, output int kind, output int unsigned ma,
                            output int unsigned mwd, output int unsigned rd);
    int unsigned op, rs1, rs2, a, b, r, c;
    bit alu;
    op  = (w >> (3*ra)) & 15;
    rd  = (w >> (2*ra)) & rmask;
    rs1 = (w >> ra) & rmask;
    rs2 = w & rmask;
    a   = mreg[4'(rs1)];
    b   = mreg[4'(rs2)];
    kind = 0; ma = a % 256; mwd = b; r = 0; c = 32'(mflags[1]); alu = 1'b1;
    case (op)
      1: begin r = a + b; c = r >> dw; end
      2: begin r = a - b; c = (a < b) ? 1 : 0; end
      3: begin r = a & b; c = 0; end
      4: begin r = a | b; c = 0; end
      5: begin r = a ^ b; c = 0; end
      6: begin r = a << 1; c = (a >> (dw - 1)) & 1; end
      7: begin r = a >> 1; c = a & 1; end
      default: alu = 1'b0;
    endcase
    r = r & dmask;
    if (alu) begin
      mflags = {1'((r >> (dw - 1)) & 1), 1'(c), r == 0};
      wr(rd, r);
      mpc = (mpc + 1) % 256;
    end else begin
      case (op)
        8:  begin wr(rd, (rs1 << ra) | rs2); mpc = (mpc + 1) % 256; end
        9:  begin wr(rd, a); mpc = (mpc + 1) % 256; end
        10: kind = 1;
        11: kind = 3;
        12: mpc = ma;
        13: mpc = mflags[0] ? ma : (mpc + 1) % 256;
        14: mpc = mflags[1] ? ma : (mpc + 1) % 256;
        15: kind = 2;
        default: mpc = (mpc + 1) % 256;
      endcase
    end
  endtask

  task automatic boot_checks(input string tag);
    chk({tag, "_ireq"}, 32'(g_ireq), 0);
    chk({tag, "_iaddr"}, 32'(g_iaddr), 0);
    chk({tag, "_dreq"}, 32'(g_dreq), 0);
    chk({tag, "_we"}, 32'(g_we), 0);
    chk({tag, "_daddr"}, 32'(g_daddr), 0);
    chk({tag, "_wdata"}, 32'(g_wdata), 0);
    chk({tag, "_flags"}, 32'(g_flags), 0);
    chk({tag, "_halted"}, 32'(g_halt), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    imem_ack = 1'b1; imem_data = 16'($urandom); dmem_ack = 1'b1;
    boot_checks("boot");
    tick();
  endtask

  // Runs one instruction from its FETCH cycle through to the next FETCH (or HALT) cycle.
  task automatic exec_one(input int iw, input int dwt);
    int kind;
    int unsigned ma, mwd, rd;
    int unsigned w;
    w = imem[8'(mpc)];
    chk("fetch_req", 32'(g_ireq), 1);
    chk("fetch_addr", 32'(g_iaddr), mpc);
    chk("flags", 32'(g_flags), 32'(mflags));
    chk("fetch_dreq", 32'(g_dreq), 0);
    chk("not_halted", 32'(g_halt), 0);
    for (int k = 0; k < iw; k++) begin
      imem_ack = 1'b0; imem_data = 16'($urandom); dmem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("fetch_wait_req", 32'(g_ireq), 1);
      chk("fetch_wait_addr", 32'(g_iaddr), mpc);
    end
    imem_ack = 1'b1; imem_data = 16'(w); dmem_ack = 1'($urandom_range(0, 1));
    tick();
    imem_ack = 1'($urandom_range(0, 1)); imem_data = 16'($urandom);
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = 16'($urandom);
    chk("exec_ireq", 32'(g_ireq), 0);
    chk("exec_dreq", 32'(g_dreq), 0);
    model_step(w, kind, ma, mwd, rd);
    tick();
    if (kind == 2) begin
      chk("halt_flag", 32'(g_halt), 1);
      chk("halt_ireq", 32'(g_ireq), 0);
    end else if (kind == 1 || kind == 3) begin
      for (int k = 0; k <= dwt; k++) begin
        chk("mem_req", 32'(g_dreq), 1);
        chk("mem_ireq", 32'(g_ireq), 0);
        chk("mem_we", 32'(g_we), (kind == 3) ? 1 : 0);
        chk("mem_addr", 32'(g_daddr), ma);
        if (kind == 3) chk("mem_wdata", 32'(g_wdata), mwd);
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = (k == dwt);
        dmem_rdata = (k == dwt) ? 16'(dmem[8'(ma)]) : 16'($urandom);
        tick();
      end
      dmem_ack = 1'b0;
      if (kind == 1) wr(rd, dmem[8'(ma)]);
      else dmem[8'(ma)] = mwd;
      mpc = (mpc + 1) % 256;
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < 256; i++) dmem[8'(i)] = 0;
    set_core(1'b0);

    // LDI/LDI/ADD/ST with zero-wait acks: 2+2+2+3 cycles.
    fill_imem(15);
    imem[0] = ldi(1, 5); imem[1] = ldi(2, 3); imem[2] = enc(1, 3, 1, 2); imem[3] = enc(11, 0, 1, 3);
    do_reset();
    c0 = cyc;
    repeat (4) exec_one(0, 0);
    chk("s1_cycles", 32'(cyc - c0), 9);
    chk("s1_flags", 32'(g_flags), 3'b000);
    exec_one(0, 0);

    // SUB with borrow, taken JC, untaken JZ.
    fill_imem(15);
    imem[0] = ldi(1, 5); imem[1] = ldi(2, 3); imem[2] = ldi(4, 8'h20);
    imem[3] = enc(2, 3, 2, 1); imem[4] = enc(14, 0, 4, 0);
    imem[8'h20] = enc(13, 0, 4, 0); imem[8'h21] = enc(11, 0, 1, 3);
    do_reset();
    repeat (5) exec_one(0, 0);
    chk("s2_jc_target", 32'(g_iaddr), 32'h20);
    chk("s2_flags", 32'(g_flags), 3'b110);
    repeat (2) exec_one(0, 0);
    chk("s2_after", 32'(g_iaddr), 32'h22);
    exec_one(0, 0);

    // Wait states on both buses.
    fill_imem(15);
    dmem[5] = 32'hA7;
    imem[0] = ldi(1, 5); imem[1] = enc(10, 5, 1, 0); imem[2] = enc(11, 0, 1, 5);
    do_reset();
    repeat (3) exec_one(3, 2);
    exec_one(3, 0);

    // PC wrap from 0xFF to 0x00.
    fill_imem(15);
    imem[0] = ldi(1, 1); imem[1] = enc(2, 4, 0, 1); imem[2] = enc(12, 0, 4, 0); imem[255] = 0;
    do_reset();
    repeat (4) exec_one(0, 0);
    chk("wrap_addr", 32'(g_iaddr), 0);
    exec_one(0, 0);

    // HALT holds off all requests while acks toggle.
    fill_imem(15);
    do_reset();
    exec_one(1, 0);
    for (int k = 0; k < 20; k++) begin
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
      imem_data = 16'($urandom);
      tick();
      chk("halt_hold", 32'(g_halt), 1);
      chk("halt_ireq", 32'(g_ireq), 0);
      chk("halt_dreq", 32'(g_dreq), 0);
    end

    // Reset while a data request is outstanding.
    fill_imem(15);
    imem[0] = ldi(1, 5); imem[1] = enc(10, 2, 1, 0);
    do_reset();
    exec_one(0, 0);
    imem_ack = 1'b1; imem_data = 16'(imem[1]);
    tick();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    chk("rst_mem_req", 32'(g_dreq), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; dmem_ack = 1'b1; imem_ack = 1'b1; dmem_rdata = 16'($urandom);
    boot_checks("rst_mem");
    tick();
    model_reset();
    exec_one(0, 0);
    exec_one(0, 1);

    // R0 is hard-wired zero, flags still update.
    fill_imem(15);
    imem[0] = ldi(0, 8'h3F); imem[1] = enc(9, 1, 0, 0); imem[2] = enc(1, 0, 1, 1);
    imem[3] = enc(11, 0, 1, 0);
    do_reset();
    repeat (3) exec_one(0, 0);
    chk("r0_flags", 32'(g_flags), 3'b001);
    repeat (2) exec_one(0, 0);

    // 16-bit data, 16 registers.
    set_core(1'b1);
    fill_imem(15);
    imem[0] = ldi(1, 5); imem[1] = ldi(2, 3); imem[2] = enc(1, 3, 1, 2); imem[3] = enc(11, 0, 1, 3);
    do_reset();
    c0 = cyc;
    repeat (4) exec_one(0, 0);
    chk("w16_cycles", 32'(cyc - c0), 9);
    chk("w16_flags", 32'(g_flags), 3'b000);
    exec_one(0, 0);

    // Random programs without HALT on both configurations.
    for (int s = 0; s < 2; s++) begin
      int unsigned w;
      set_core(1'(s));
      for (int i = 0; i < 256; i++) begin
        w = $urandom % (32'd1 << (4 + 3*ra));
        if (((w >> (3*ra)) & 15) == 15) w = w & ~(32'd15 << (3*ra));
        imem[8'(i)] = w;
        dmem[8'(i)] = $urandom & dmask;
      end
      do_reset();
      repeat (300) exec_one($urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
